// File: rtl/mem_1rw_req_adapter.sv
// Valid/ready request front end for a 1RW synchronous SRAM, returning read data in order.
// Optional MEM_1RW_REQ_ADAPTER_BYPASS_EN forwards mem_data_i straight to data_o when the buffer is empty.
module mem_1rw_req_adapter #(
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int ELS        = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  v_i,
    output logic                  ready_o,
    input  logic                  w_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic [WIDTH/8-1:0]    wmask_i,
    output logic                  mem_v_o,
    output logic                  mem_w_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_data_o,
    output logic [WIDTH-1:0]      mem_wmask_o,
    input  logic [WIDTH-1:0]      mem_data_i,
    output logic                  v_o,
    output logic [WIDTH-1:0]      data_o,
    input  logic                  yumi_i
);
    localparam int PW = (ELS > 1) ? $clog2(ELS) : 1;
    localparam int CW = $clog2(ELS + 1);
    localparam int MW = WIDTH / 8;

    logic [WIDTH-1:0] buf_q [ELS];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rd_pend_q, rd_pend_d;
    logic [CW:0]      occ;
    logic             fire, push, pop, bypass;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(ELS - 1)) ? '0 : p + 1'b1;
    endfunction

    // An outstanding read already owns a buffer slot, so it counts toward occupancy.
    assign occ     = {1'b0, count_q} + {{CW{1'b0}}, rd_pend_q};
    assign ready_o = ~reset_i & (occ < (CW+1)'(ELS));
    assign fire    = v_i & ready_o;

    assign mem_v_o    = fire;
    assign mem_w_o    = fire & w_i;
    assign mem_addr_o = addr_i;
    assign mem_data_o = data_i;

    always_comb begin
        mem_wmask_o = '0;
        for (int b = 0; b < MW; b++) begin
            mem_wmask_o[8*b +: 8] = {8{wmask_i[b] & mem_w_o}};
        end
    end

`ifdef MEM_1RW_REQ_ADAPTER_BYPASS_EN
    assign bypass = ~reset_i & rd_pend_q & (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    assign v_o    = (count_q != '0) | bypass;
    assign data_o = bypass ? mem_data_i : buf_q[head_q];
    // Data consumed straight off the bypass path never enters the buffer.
    assign pop    = yumi_i & (count_q != '0);
    assign push   = rd_pend_q & ~(bypass & yumi_i);

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        rd_pend_d = fire & ~w_i;
        if (push) tail_d = ptr_inc(tail_q);
        if (pop)  head_d = ptr_inc(head_q);
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) buf_q[tail_q] <= mem_data_i;
    end

    a_no_yumi_when_empty: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));

endmodule

// File: tb/tb_mem_1rw_req_adapter.sv
// Directed bench for mem_1rw_req_adapter: one ELS=2 and one ELS=3 instance, each with its own SRAM model.
module tb_mem_1rw_req_adapter;
    localparam int W  = 64;
    localparam int AW = 9;
    localparam int MW = 8;
`ifdef MEM_1RW_REQ_ADAPTER_BYPASS_EN
    localparam bit BYP     = 1'b1;
    localparam int EXP_S2  = 12;
`else
    localparam bit BYP     = 1'b0;
    localparam int EXP_S2  = 8;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          mem_init;
    logic          v [2], w [2], ready [2], mv [2], mw [2], vo [2], yumi [2];
    logic [AW-1:0] addr [2], maddr [2];
    logic [W-1:0]  data [2], mdo [2], mwm [2], mdi [2], dout [2];
    logic [MW-1:0] wm [2];
    logic [W-1:0]  mem [2][512];
    logic          seen [2][512];
    int            n_chk = 0;
    int            n_err = 0;

    mem_1rw_req_adapter #(.WIDTH(W), .ADDR_WIDTH(AW), .ELS(2)) u_els2 (
        .clk_i(clk), .reset_i(rst), .v_i(v[0]), .ready_o(ready[0]), .w_i(w[0]),
        .addr_i(addr[0]), .data_i(data[0]), .wmask_i(wm[0]), .mem_v_o(mv[0]), .mem_w_o(mw[0]),
        .mem_addr_o(maddr[0]), .mem_data_o(mdo[0]), .mem_wmask_o(mwm[0]), .mem_data_i(mdi[0]),
        .v_o(vo[0]), .data_o(dout[0]), .yumi_i(yumi[0]));

    mem_1rw_req_adapter #(.WIDTH(W), .ADDR_WIDTH(AW), .ELS(3)) u_els3 (
        .clk_i(clk), .reset_i(rst), .v_i(v[1]), .ready_o(ready[1]), .w_i(w[1]),
        .addr_i(addr[1]), .data_i(data[1]), .wmask_i(wm[1]), .mem_v_o(mv[1]), .mem_w_o(mw[1]),
        .mem_addr_o(maddr[1]), .mem_data_o(mdo[1]), .mem_wmask_o(mwm[1]), .mem_data_i(mdi[1]),
        .v_o(vo[1]), .data_o(dout[1]), .yumi_i(yumi[1]));

    function automatic logic [W-1:0] pat(input int a);
        return {32'hC0DE_0000 | a, ~a};
    endfunction

    // SRAM model: unwritten locations read back as pat(addr); 1-cycle read latency.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_init) begin
                for (int a = 0; a < 512; a++) seen[d][a] <= 1'b0;
            end else if (mv[d]) begin
                if (mw[d]) begin
                    mem[d][maddr[d]]  <= ((seen[d][maddr[d]] ? mem[d][maddr[d]] : pat(int'(maddr[d])))
                                          & ~mwm[d]) | (mdo[d] & mwm[d]);
                    seen[d][maddr[d]] <= 1'b1;
                end else begin
                    mdi[d] <= seen[d][maddr[d]] ? mem[d][maddr[d]] : pat(int'(maddr[d]));
                end
            end
        end
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d);
        v[d] = 1'b0; w[d] = 1'b0; addr[d] = '0; data[d] = '0; wm[d] = '0; yumi[d] = 1'b0;
    endtask

    // Issue reads to consecutive addresses from base for n_cyc cycles; consumer pops whenever v_o.
    task automatic stream(input int d, input int n_cyc, input int base, input int exp_acc, input string tag);
        int acc = 0;
        int rcv = 0;
        for (int k = 0; (k < n_cyc) || (rcv < acc && k < n_cyc + 20); k++) begin
            cyc();
            v[d] = (k < n_cyc); w[d] = 1'b0; addr[d] = AW'(base + acc);
            #1;
            yumi[d] = vo[d];
            @(negedge clk);
            if (v[d] && ready[d]) acc++;
            if (yumi[d]) begin
                check({tag, "_data"}, dout[d], pat(base + rcv));
                rcv++;
            end
        end
        cyc();
        idle(0 + d);
        check({tag, "_accepted"}, W'(acc), W'(exp_acc));
        check({tag, "_returned"}, W'(rcv), W'(exp_acc));
    endtask

    initial begin
        rst = 1'b1;
        mem_init = 1'b1;
        idle(0);
        idle(1);
        repeat (2) @(posedge clk);
        mem_init = 1'b0;
        @(negedge clk);
        check("rst_ready", W'(ready[0]), W'(0));
        check("rst_v_o", W'(vo[0]), W'(0));
        cyc();
        rst = 1'b0;
        #1;
        check("post_rst_ready", W'(ready[0]), W'(1));
        check("post_rst_v_o", W'(vo[0]), W'(0));

        // full write then read back
        cyc();
        v[0] = 1'b1; w[0] = 1'b1; addr[0] = 9'd5; data[0] = 64'h1122334455667788; wm[0] = 8'hFF;
        #1;
        check("wr_mem_v", W'(mv[0]), W'(1));
        check("wr_mem_w", W'(mw[0]), W'(1));
        check("wr_wmask", mwm[0], {W{1'b1}});
        check("wr_addr", W'(maddr[0]), W'(5));
        check("wr_data", mdo[0], 64'h1122334455667788);
        cyc();
        w[0] = 1'b0;
        #1;
        check("rd_mem_v", W'(mv[0]), W'(1));
        check("rd_mem_w", W'(mw[0]), W'(0));
        check("rd_wmask", mwm[0], '0);
        cyc();
        idle(0);
        #1;
        check("rd_lat1_v_o", W'(vo[0]), W'(BYP));
        if (BYP) check("rd_lat1_data", dout[0], 64'h1122334455667788);
        cyc();
        yumi[0] = 1'b1;
        #1;
        check("rd_lat2_v_o", W'(vo[0]), W'(1));
        check("rd_lat2_data", dout[0], 64'h1122334455667788);
        cyc();
        yumi[0] = 1'b0;
        #1;
        check("rd_drained_v_o", W'(vo[0]), W'(0));

        // partial write of byte 0
        cyc();
        v[0] = 1'b1; w[0] = 1'b1; addr[0] = 9'd5; data[0] = 64'hAA; wm[0] = 8'h01;
        #1;
        check("pw_wmask", mwm[0], 64'h0000_0000_0000_00FF);
        cyc();
        w[0] = 1'b0; wm[0] = '0;
        cyc();
        idle(0);
        cyc();
        yumi[0] = 1'b1;
        #1;
        check("pw_v_o", W'(vo[0]), W'(1));
        check("pw_data", dout[0], 64'h1122_3344_5566_77AA);
        cyc();
        idle(0);

        // consumer stall: third read must wait for a pop
        cyc();
        v[0] = 1'b1; w[0] = 1'b0; addr[0] = 9'd0;
        #1;
        check("st_ready0", W'(ready[0]), W'(1));
        cyc();
        addr[0] = 9'd1;
        #1;
        check("st_ready1", W'(ready[0]), W'(1));
        cyc();
        addr[0] = 9'd2;
        #1;
        check("st_ready2", W'(ready[0]), W'(0));
        check("st_mem_v2", W'(mv[0]), W'(0));
        cyc();
        #1;
        check("st_ready3", W'(ready[0]), W'(0));
        check("st_v_o3", W'(vo[0]), W'(1));
        cyc();
        yumi[0] = 1'b1;
        #1;
        check("st_ready4", W'(ready[0]), W'(0));
        check("st_data0", dout[0], pat(0));
        cyc();
        #1;
        check("st_ready5", W'(ready[0]), W'(1));
        check("st_data1", dout[0], pat(1));
        cyc();
        v[0] = 1'b0; yumi[0] = 1'b0;
        cyc();
        yumi[0] = 1'b1;
        #1;
        check("st_data2", dout[0], pat(2));
        cyc();
        idle(0);

        // reset the cycle after a read accept
        cyc();
        v[0] = 1'b1; w[0] = 1'b0; addr[0] = 9'd3;
        #1;
        check("mr_accept", W'(ready[0]), W'(1));
        cyc();
        idle(0);
        rst = 1'b1;
        #1;
        check("mr_rst_v_o", W'(vo[0]), W'(0));
        check("mr_rst_ready", W'(ready[0]), W'(0));
        cyc();
        rst = 1'b0;
        #1;
        check("mr_v_o_a", W'(vo[0]), W'(0));
        check("mr_ready", W'(ready[0]), W'(1));
        cyc();
        #1;
        check("mr_v_o_b", W'(vo[0]), W'(0));

        stream(0, 12, 16, EXP_S2, "s2");
        stream(1, 12, 32, 12, "s3");
        stream(1, 10, 64, 10, "wrap3");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_1rw_req_adapter.md
Name: mem_1rw_req_adapter

Overview:
- Valid/ready front end that sits directly upstream of a 1RW synchronous SRAM wrapper, such as the 512x64 byte-mask hard-memory wrapper.
- Accepts read and write requests, drives the SRAM port, and captures the 1-cycle-latency read data into a small output buffer.
- Read data is returned to the consumer with valid/yumi flow control.
- Credit accounting guarantees that no read data is lost when the consumer stalls.

Parameters:
- WIDTH, 64, data width in bits; must be a multiple of 8.
- ADDR_WIDTH, 9, SRAM address width.
- ELS, 2, read-return buffer depth in entries; must be >= 2.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  synchronous active-high reset.
- v_i  in  1  request valid.
- ready_o  out  1  adapter can accept a request this cycle.
- w_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  request address.
- data_i  in  WIDTH  write data.
- wmask_i  in  WIDTH/8  byte write enables.
- mem_v_o  out  1  SRAM access enable.
- mem_w_o  out  1  SRAM write enable.
- mem_addr_o  out  ADDR_WIDTH  SRAM address.
- mem_data_o  out  WIDTH  SRAM write data.
- mem_wmask_o  out  WIDTH  bit mask; byte b of wmask_i replicated across 8 bits.
- mem_data_i  in  WIDTH  SRAM read data, valid the cycle after a read access.
- v_o  out  1  read data valid.
- data_o  out  WIDTH  read data.
- yumi_i  in  1  consumer takes data_o this cycle; legal only when v_o=1.

Behaviour:
- Clock and reset: one clock, clk_i; reset is synchronous and active-high, on reset_i.
- Reset: count, rd_pend and head/tail pointers cleared. v_o=0. ready_o=0 while reset_i=1. Outputs are valid the first cycle after reset deasserts.
- Reset mid-operation: an in-flight read (rd_pend=1) is discarded. Buffered entries are dropped. mem_data_i in the cycle after reset is ignored.
- State: rd_pend (1 bit); count (0..ELS); circular buffer of ELS x WIDTH with head/tail pointers that wrap at ELS (ELS need not be a power of 2).
- ready_o = ~reset_i & ((count + rd_pend) < ELS).
  - Depends on registered state only; no combinational path from yumi_i or v_i.
  - Applies to writes as well as reads.
- Accept: fire = v_i & ready_o.
  - mem_v_o = fire. mem_w_o = fire & w_i.
  - mem_addr_o = addr_i, mem_data_o = data_i, mem_wmask_o = expanded wmask_i; all combinational pass-through.
  - mem_wmask_o = 0 when mem_w_o=0.
- Reads: rd_pend <= fire & ~w_i. In the next cycle, mem_data_i is written into the buffer at tail.
- Writes produce no response and never set rd_pend.
- Output: v_o = (count != 0). data_o = buf[head]. yumi_i pops head.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Ordering: read data is returned strictly in request order.
- Throughput: ELS=2 sustains 2 reads per 3 cycles. ELS>=3 sustains 1 read per cycle. Writes: 1 per cycle whenever ready_o=1.
- Full: with count + rd_pend == ELS, ready_o=0 and no SRAM access is issued.
- yumi_i with v_o=0 is illegal; it is an assertion failure and state is unchanged.

Optional Feature:
- Macro: MEM_1RW_REQ_ADAPTER_BYPASS_EN.
- Defined: when count==0 and rd_pend==1, then v_o=1 and data_o=mem_data_i combinationally.
  - If yumi_i=1 in that cycle, the data is not written to the buffer.
  - Read latency becomes 1 cycle.
  - ELS=2 sustains 1 read per cycle with a non-stalling consumer.
- Undefined: read data is always registered into the buffer first. Minimum accept-to-v_o latency is 2 cycles.

Test Plan:
- Reset, then write A=0x5 with data 0x1122334455667788 and wmask 0xFF, then read A=0x5.
  - mem_wmask_o all ones during the write.
  - data_o=0x1122334455667788 with v_o=1 two cycles after read accept (one cycle with BYPASS_EN).
- Partial write: wmask_i=0x01, data 0xAA to A=0x5, then read A=0x5 -> data_o=0x11223344556677AA. mem_wmask_o=0x00000000000000FF during the write.
- Consumer stall: yumi_i=0, issue 3 reads to addresses 0,1,2 with ELS=2.
  - Only 2 are accepted; ready_o=0 after the second until a pop occurs.
  - Data is returned in order 0,1 once yumi_i=1.
- Streaming: 12 back-to-back reads with yumi_i held 1.
  - ELS=2 without bypass: exactly 8 accepted in 12 cycles.
  - ELS=3, or ELS=2 with BYPASS_EN: 12 accepted; no data lost or reordered.
- Reset mid-read: assert reset_i the cycle after a read accept -> v_o=0, count=0 after reset; no stale data is ever presented.
- Simultaneous push and pop with count=1 (yumi_i=1 while read data returns) -> count stays 1; head and tail wrap correctly at ELS=3 over 10 transactions.
